axi_slave_mux_w_n: RTL and testbench

// - Write-path slave-side mux of the AXI interconnect, generalised from 1 to NUM_SLAVES targets.
// - Decodes AWADDR against per-slave base/mask windows and routes AW, W and B handshakes to the hit slave.
// - Tracks one write burst at a time and returns B to the master.
// - Unmapped addresses get a DECERR from an internal default slave.

---
 rtl/axi_pkg.sv | 20 ++
 rtl/axi_addr_decoder.sv | 34 +++
 rtl/axi_slave_mux_w_n.sv | 146 ++++++++++++++
 tb/tb_axi_slave_mux_w_n.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants and the write-mux state encoding.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    BRESP,
    DERR_W,
    DERR_B
  } state_e;

  // Index width that stays legal when there is only one target.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_addr_decoder.sv
// Address window decoder: lowest-indexed matching base/mask window wins.
module axi_addr_decoder
  import axi_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = '0,
  localparam int unsigned IDX_W = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_SLAVES-1:0] hit_onehot_o,
  output logic [IDX_W-1:0]      hit_idx_o,
  output logic                  miss_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // one unassigned, which would infer a latch.
    hit_onehot_o = '0;
    hit_idx_o    = '0;
    miss_o       = 1'b1;
    // Scan from the top down so the lowest matching index is written last.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_onehot_o    = '0;
        hit_onehot_o[i] = 1'b1;
        hit_idx_o       = i[IDX_W-1:0];
        miss_o          = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_slave_mux_w_n.sv
// Write-path slave mux: routes one AW/W/B burst at a time to the decoded
// slave, or absorbs it in an internal DECERR slave when no window matches.
module axi_slave_mux_w_n
  import axi_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned USER_WIDTH = 1,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = {32'h1c00_0000, 32'h0},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {32'hff00_0000, 32'hf000_0000}
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          s_AWADDR,
  input  logic [ID_WIDTH-1:0]            s_AWID,
  input  logic                           s_AWVALID,
  output logic                           m_AWREADY,
  input  logic                           s_WVALID,
  input  logic                           s_WLAST,
  output logic                           m_WREADY,
  output logic [ID_WIDTH-1:0]            m_BID,
  output logic [1:0]                     m_BRESP,
  output logic [USER_WIDTH-1:0]          m_BUSER,
  output logic                           m_BVALID,
  input  logic                           s_BREADY,
  output logic [NUM_SLAVES-1:0]          sx_AWVALID,
  input  logic [NUM_SLAVES-1:0]          sx_AWREADY,
  output logic [NUM_SLAVES-1:0]          sx_WVALID,
  input  logic [NUM_SLAVES-1:0]          sx_WREADY,
  input  logic [NUM_SLAVES*ID_WIDTH-1:0] sx_BID,
  input  logic [NUM_SLAVES*2-1:0]        sx_BRESP,
  input  logic [NUM_SLAVES*USER_WIDTH-1:0] sx_BUSER,
  input  logic [NUM_SLAVES-1:0]          sx_BVALID,
  output logic [NUM_SLAVES-1:0]          sx_BREADY
);

  localparam int unsigned IDX_W = idx_width(NUM_SLAVES);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [ID_WIDTH-1:0] id_q, id_d;

  logic [NUM_SLAVES-1:0] hit_onehot;
  logic [IDX_W-1:0]      hit_idx;
  logic                  miss;

  axi_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_dec (
    .addr_i       (s_AWADDR),
    .hit_onehot_o (hit_onehot),
    .hit_idx_o    (hit_idx),
    .miss_o       (miss)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge value, independent of statement order.
    if (!ARESETn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    id_d       = id_q;
    m_AWREADY  = 1'b0;
    m_WREADY   = 1'b0;
    m_BID      = '0;
    m_BRESP    = RESP_OKAY;
    m_BUSER    = '0;
    m_BVALID   = 1'b0;
    sx_AWVALID = '0;
    sx_WVALID  = '0;
    sx_BREADY  = '0;

    unique case (state_q)
      IDLE: begin
        if (miss) begin
          m_AWREADY = s_AWVALID;
          if (s_AWVALID) begin
            id_d    = s_AWID;
            state_d = DERR_W;
          end
        end else begin
          sx_AWVALID = hit_onehot & {NUM_SLAVES{s_AWVALID}};
          m_AWREADY  = s_AWVALID & sx_AWREADY[hit_idx];
          if (s_AWVALID && sx_AWREADY[hit_idx]) begin
            sel_d   = hit_idx;
            id_d    = s_AWID;
            state_d = WDATA;
          end
        end
      end
      WDATA: begin
        sx_WVALID[sel_q] = s_WVALID;
        m_WREADY         = sx_WREADY[sel_q];
        if (s_WVALID && sx_WREADY[sel_q] && s_WLAST) state_d = BRESP;
      end
      BRESP: begin
        m_BVALID         = sx_BVALID[sel_q];
        m_BID            = sx_BID[int'(sel_q)*ID_WIDTH +: ID_WIDTH];
        m_BRESP          = sx_BRESP[int'(sel_q)*2 +: 2];
        m_BUSER          = sx_BUSER[int'(sel_q)*USER_WIDTH +: USER_WIDTH];
        sx_BREADY[sel_q] = s_BREADY;
        if (sx_BVALID[sel_q] && s_BREADY) state_d = IDLE;
      end
      DERR_W: begin
        m_WREADY = 1'b1;
        if (s_WVALID && s_WLAST) state_d = DERR_B;
      end
      DERR_B: begin
        m_BVALID = 1'b1;
        m_BID    = id_q;
        m_BRESP  = RESP_DECERR;
        if (s_BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced quiet while reset is held, not just from the next edge.
    if (!ARESETn) begin
      m_AWREADY  = 1'b0;
      m_WREADY   = 1'b0;
      m_BID      = '0;
      m_BRESP    = RESP_OKAY;
      m_BUSER    = '0;
      m_BVALID   = 1'b0;
      sx_AWVALID = '0;
      sx_WVALID  = '0;
      sx_BREADY  = '0;
    end
  end

endmodule

// File: tb/tb_axi_slave_mux_w_n.sv
// Directed bench for the write-path slave mux with a transaction-level model
// checked against the DUT on every falling edge.
module tb_axi_slave_mux_w_n;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_AWADDR;
  logic [0:0]  s_AWID;
  logic        s_AWVALID, s_WVALID, s_WLAST, s_BREADY;
  logic        m_AWREADY, m_WREADY, m_BVALID;
  logic [0:0]  m_BID, m_BUSER;
  logic [1:0]  m_BRESP;
  logic [1:0]  sx_AWVALID, sx_AWREADY, sx_WVALID, sx_WREADY;
  logic [1:0]  sx_BID, sx_BUSER, sx_BVALID, sx_BREADY;
  logic [3:0]  sx_BRESP;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_slave_mux_w_n #(
    .NUM_SLAVES (2), .ADDR_WIDTH (32), .ID_WIDTH (1), .USER_WIDTH (1),
    .SLV_BASE ({32'h1c00_0000, 32'h0}),
    .SLV_MASK ({32'hff00_0000, 32'hf000_0000})
  ) dut (
    .ACLK (clk), .ARESETn (rst_n),
    .s_AWADDR (s_AWADDR), .s_AWID (s_AWID), .s_AWVALID (s_AWVALID), .m_AWREADY (m_AWREADY),
    .s_WVALID (s_WVALID), .s_WLAST (s_WLAST), .m_WREADY (m_WREADY),
    .m_BID (m_BID), .m_BRESP (m_BRESP), .m_BUSER (m_BUSER), .m_BVALID (m_BVALID), .s_BREADY (s_BREADY),
    .sx_AWVALID (sx_AWVALID), .sx_AWREADY (sx_AWREADY),
    .sx_WVALID (sx_WVALID), .sx_WREADY (sx_WREADY),
    .sx_BID (sx_BID), .sx_BRESP (sx_BRESP), .sx_BUSER (sx_BUSER),
    .sx_BVALID (sx_BVALID), .sx_BREADY (sx_BREADY)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Address map as plain tables; first matching window in index order wins.
  logic [31:0] base_tbl [N] = '{32'h0000_0000, 32'h1c00_0000};
  logic [31:0] mask_tbl [N] = '{32'hf000_0000, 32'hff00_0000};

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & mask_tbl[i]) == base_tbl[i]) return i;
    return N;  // N stands for the internal error slave
  endfunction

  // Transaction model: which phase of the single outstanding burst we are in.
  int          ph  = 0;  // 0 address, 1 data, 2 response
  int          tgt = 0;
  logic [0:0]  lid = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = 0;
    end else if (ph == 0) begin
      if (s_AWVALID && (decode(s_AWADDR) == N || sx_AWREADY[decode(s_AWADDR)])) begin
        tgt = decode(s_AWADDR);
        lid = s_AWID;
        ph  = 1;
      end
    end else if (ph == 1) begin
      if (s_WVALID && s_WLAST && (tgt == N || sx_WREADY[tgt])) ph = 2;
    end else begin
      if (s_BREADY && (tgt == N || sx_BVALID[tgt])) ph = 0;
    end
  end

  // Output bundle: {awready, wready, bid, bresp, buser, bvalid, sx_awvalid, sx_wvalid, sx_bready}
  logic [12:0] act_bus;
  assign act_bus = {m_AWREADY, m_WREADY, m_BID, m_BRESP, m_BUSER, m_BVALID,
                    sx_AWVALID, sx_WVALID, sx_BREADY};

  always @(negedge clk) begin
    logic       e_awr, e_wr, e_bv;
    logic [0:0] e_bid, e_bu;
    logic [1:0] e_br, e_sxaw, e_sxw, e_sxb;
    int t;
    e_awr = 0; e_wr = 0; e_bv = 0; e_bid = 0; e_bu = 0; e_br = 0;
    e_sxaw = 0; e_sxw = 0; e_sxb = 0;
    if (rst_n) begin
      if (ph == 0) begin
        t = decode(s_AWADDR);
        if (t == N) e_awr = s_AWVALID;
        else begin
          e_sxaw[t] = s_AWVALID;
          e_awr     = s_AWVALID && sx_AWREADY[t];
        end
      end else if (ph == 1) begin
        if (tgt == N) e_wr = 1;
        else begin
          e_sxw[tgt] = s_WVALID;
          e_wr       = sx_WREADY[tgt];
        end
      end else begin
        if (tgt == N) begin
          e_bv = 1; e_bid = lid; e_br = 2'b11;
        end else begin
          e_bv = sx_BVALID[tgt]; e_bid = sx_BID[tgt]; e_bu = sx_BUSER[tgt];
          e_br = sx_BRESP[2*tgt +: 2]; e_sxb[tgt] = s_BREADY;
        end
      end
    end
    check("cycle_outputs", {19'd0, act_bus},
          {19'd0, e_awr, e_wr, e_bid, e_br, e_bu, e_bv, e_sxaw, e_sxw, e_sxb});
  end

  // Beats accepted by each slave, and whether any slave-side valid was seen.
  int beats [N];
  logic sx_seen;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) if (sx_WVALID[i] && sx_WREADY[i]) beats[i]++;
    if (|sx_AWVALID || |sx_WVALID) sx_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_AWVALID = 0; s_WVALID = 0; s_WLAST = 0; s_BREADY = 0;
    sx_AWREADY = 0; sx_WREADY = 0; sx_BVALID = 0;
    sx_BID = 0; sx_BRESP = 0; sx_BUSER = 0;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [0:0] id);
    s_AWADDR = a; s_AWID = id; s_AWVALID = 1; sx_AWREADY = 2'b11;
    tick();
    s_AWVALID = 0; sx_AWREADY = 0;
  endtask

  task automatic do_w(input int n);
    s_WVALID = 1; sx_WREADY = 2'b11;
    for (int i = 0; i < n; i++) begin
      s_WLAST = (i == n - 1);
      tick();
    end
    s_WVALID = 0; s_WLAST = 0; sx_WREADY = 0;
  endtask

  task automatic do_b(input int slv);
    sx_BVALID = 2'b11; sx_BRESP = 4'b0110; sx_BID = 2'b10; s_BREADY = 1;
    #1;
    check("b_resp_routed", {30'd0, m_BRESP}, (slv == 0) ? 32'd2 : 32'd1);
    tick();
    clear_inputs();
  endtask

  initial begin
    s_AWADDR = 0; s_AWID = 0; clear_inputs();
    beats[0] = 0; beats[1] = 0; sx_seen = 0;
    rst_n = 0;
    check("model_decode_s1", decode(32'h1c00_0010), 1);
    check("model_decode_miss", decode(32'h8000_0000), 2);

    // Reset holds all outputs low even with a hitting, ready request.
    s_AWADDR = 32'h1c00_0010; s_AWVALID = 1; sx_AWREADY = 2'b11;
    tick(); tick();
    check("reset_outputs", {19'd0, act_bus}, 0);
    clear_inputs();
    rst_n = 1;
    tick();

    // 4-beat burst to slave1 with OKAY response.
    s_AWADDR = 32'h1c00_0010; s_AWID = 0; s_AWVALID = 1; sx_AWREADY = 2'b11;
    #1;
    check("s1_awvalid", {30'd0, sx_AWVALID}, 2'b10);
    check("s1_awready", {31'd0, m_AWREADY}, 1);
    tick();
    s_AWVALID = 0; sx_AWREADY = 0;
    do_w(4);
    check("s1_beats", beats[1], 4);
    sx_BVALID = 2'b10; sx_BRESP = 4'b0010; sx_BID = 2'b10; s_BREADY = 1;
    #1;
    check("s1_bresp", {29'd0, m_BVALID, m_BRESP}, 3'b100);
    tick();
    clear_inputs();

    // Slave0 stalls WREADY for 3 cycles.
    beats[0] = 0;
    do_aw(32'h0000_0100, 0);
    s_WVALID = 1; sx_WREADY = 0;
    for (int i = 0; i < 3; i++) tick();
    check("s0_stall_wready", {31'd0, m_WREADY}, 0);
    sx_WREADY = 2'b01;
    tick();
    s_WLAST = 1;
    tick();
    s_WVALID = 0; s_WLAST = 0; sx_WREADY = 0;
    check("s0_beats", beats[0], 2);
    do_b(0);

    // Unmapped address: internal DECERR slave.
    sx_seen = 0;
    s_AWADDR = 32'h8000_0000; s_AWID = 1; s_AWVALID = 1;
    #1;
    check("derr_awready", {31'd0, m_AWREADY}, 1);
    tick();
    s_AWVALID = 0;
    s_WVALID = 1;
    #1;
    check("derr_wready", {31'd0, m_WREADY}, 1);
    tick();
    s_WLAST = 1;
    tick();
    s_WVALID = 0; s_WLAST = 0;
    #1;
    check("derr_b", {28'd0, m_BVALID, m_BID, m_BRESP}, 4'b1111);
    s_BREADY = 1;
    tick();
    s_BREADY = 0;
    check("derr_no_sx_valid", {31'd0, sx_seen}, 0);

    // W before AW stalls, then routes to slave1.
    s_AWADDR = 32'h1c00_0000; s_AWID = 0; s_WVALID = 1; s_WLAST = 1; sx_WREADY = 2'b11;
    tick(); tick();
    check("early_w_wready", {31'd0, m_WREADY}, 0);
    s_AWVALID = 1; sx_AWREADY = 2'b11;
    tick();
    s_AWVALID = 0; sx_AWREADY = 0;
    #1;
    check("early_w_routed", {30'd0, sx_WVALID}, 2'b10);
    tick();
    clear_inputs();
    do_b(1);

    // Second AW waits while B is back-pressured for 5 cycles.
    do_aw(32'h0000_0200, 0);
    do_w(1);
    sx_BVALID = 2'b01; s_BREADY = 0;
    s_AWADDR = 32'h1c00_0020; s_AWVALID = 1; sx_AWREADY = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    check("bp_awready_low", {31'd0, m_AWREADY}, 0);
    s_BREADY = 1;
    tick();
    s_BREADY = 0; sx_BVALID = 0;
    #1;
    check("bp_awready_after", {31'd0, m_AWREADY}, 1);
    tick();
    s_AWVALID = 0; sx_AWREADY = 0;
    do_w(1);
    do_b(1);

    // Reset mid-burst, then a fresh burst to slave0.
    do_aw(32'h0000_0300, 0);
    s_WVALID = 1; sx_WREADY = 2'b11;
    tick();
    rst_n = 0;
    #1;
    check("midreset_outputs", {19'd0, act_bus}, 0);
    tick();
    clear_inputs();
    rst_n = 1;
    tick();
    beats[0] = 0;
    do_aw(32'h0000_0400, 0);
    do_w(3);
    check("post_reset_beats", beats[0], 3);
    do_b(0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
